// File: rtl/reg_cmd_ctrl.sv
// Command front-end for the register file: decodes UART byte frames into
// register-file read/write strobes and forwards read data to UART TX.
module reg_cmd_ctrl #(
  parameter int               Add_Bus = 4,
  parameter int               Width   = 8,
  parameter logic [Width-1:0] WR_CMD  = 8'hAA,
  parameter logic [Width-1:0] RD_CMD  = 8'hBB
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [Width-1:0]   RX_P_Data,
  input  logic               RX_D_Vld,
  input  logic [Width-1:0]   RdData,
  input  logic               RdData_Valid,
  input  logic               TX_Busy,
  output logic [Add_Bus-1:0] Address,
  output logic [Width-1:0]   WrData,
  output logic               WrEn,
  output logic               RdEn,
  output logic [Width-1:0]   TX_P_Data,
  output logic               TX_D_Vld,
  output logic               Cmd_Err
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_HOLD
  } state_t;

  // Counter reaches this value in the last cycle read data may still arrive.
  localparam logic [2:0] TMO_LAST = 3'd4;

  state_t             state, state_nxt;
  logic [2:0]         tmo_cnt, tmo_cnt_nxt;
  logic [Add_Bus-1:0] addr_nxt;
  logic [Width-1:0]   wrdata_nxt, txdata_nxt;
  logic               wren_nxt, rden_nxt, txvld_nxt, err_nxt;
  logic               is_wr_cmd, is_rd_cmd;

  assign is_wr_cmd = (RX_P_Data == WR_CMD);
  assign is_rd_cmd = (RX_P_Data == RD_CMD);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_Data <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      TX_D_Vld  <= 1'b0;
      Cmd_Err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
      Address   <= addr_nxt;
      WrData    <= wrdata_nxt;
      TX_P_Data <= txdata_nxt;
      WrEn      <= wren_nxt;
      RdEn      <= rden_nxt;
      TX_D_Vld  <= txvld_nxt;
      Cmd_Err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (RX_D_Vld) begin
          if (is_wr_cmd)      state_nxt = WR_ADDR;
          else if (is_rd_cmd) state_nxt = RD_ADDR;
        end
      end
      WR_ADDR: if (RX_D_Vld) state_nxt = WR_DATA;
      WR_DATA: if (RX_D_Vld) state_nxt = IDLE;
      RD_ADDR: if (RX_D_Vld) state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (RdData_Valid)             state_nxt = TX_Busy ? TX_HOLD : IDLE;
        else if (tmo_cnt == TMO_LAST) state_nxt = IDLE;
      end
      TX_HOLD: if (!TX_Busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Computes the next value of every registered output.
  always_comb begin
    addr_nxt    = Address;
    wrdata_nxt  = WrData;
    txdata_nxt  = TX_P_Data;
    tmo_cnt_nxt = tmo_cnt;
    wren_nxt    = 1'b0;
    rden_nxt    = 1'b0;
    txvld_nxt   = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: err_nxt = RX_D_Vld && !is_wr_cmd && !is_rd_cmd;
      WR_ADDR: if (RX_D_Vld) addr_nxt = RX_P_Data[Add_Bus-1:0];
      WR_DATA: begin
        if (RX_D_Vld) begin
          wrdata_nxt = RX_P_Data;
          wren_nxt   = 1'b1;
        end
      end
      RD_ADDR: begin
        if (RX_D_Vld) begin
          addr_nxt    = RX_P_Data[Add_Bus-1:0];
          rden_nxt    = 1'b1;
          tmo_cnt_nxt = '0;
        end
      end
      RD_WAIT: begin
        err_nxt = RX_D_Vld;
        if (RdData_Valid) begin
          txdata_nxt = RdData;
          txvld_nxt  = !TX_Busy;
        end else if (tmo_cnt == TMO_LAST) begin
          err_nxt = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 3'd1;
        end
      end
      TX_HOLD: begin
        err_nxt   = RX_D_Vld;
        txvld_nxt = !TX_Busy;
      end
      default: ;
    endcase
  end

endmodule
